// File: rtl/ring_pkg.sv
// Shared constants and helpers for blocks that sit around a RingBuffer instance.
package ring_pkg;

  localparam int RING_DATA_WIDTH  = 8;
  localparam int RING_LENGTH_BITS = 3;

  // RingBuffer keeps one slot empty to tell full from empty, so usable
  // entries are one less than the slot count.
  function automatic int ring_capacity(input int length_bits);
    return (1 << length_bits) - 1;
  endfunction

  // Per-edge occupancy action chosen from (grant, ack).
  typedef enum logic [1:0] {
    OCC_HOLD = 2'd0,
    OCC_INC  = 2'd1,
    OCC_DEC  = 2'd2
  } occ_op_e;

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: searches upward from the slot after
// last_grant, wrapping, and returns a one-hot grant plus the winner index.
module rr_priority_picker #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_grant,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   winner
);

  // First requester at or after last_grant+1 (mod NUM_REQ) wins.
  always_comb begin
    logic found;
    // NOTE: every output gets a default before the loop so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    grant  = '0;
    winner = '0;
    found  = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      automatic int idx = (int'(last_grant) + k) % NUM_REQ;
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        winner     = idx[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/ring_write_arbiter.sv
// Round-robin arbiter sharing one RingBuffer write port among NUM_REQ
// producers. Tracks occupancy from accepted writes and returned read acks and
// withholds grants while the buffer is full.
module ring_write_arbiter
  import ring_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int DATA_WIDTH  = RING_DATA_WIDTH,
  parameter int LENGTH_BITS = RING_LENGTH_BITS,
  parameter int CAPACITY    = ring_capacity(LENGTH_BITS)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            reqValid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] reqData,
  output logic [NUM_REQ-1:0]            reqGrant,
  output logic                          ringWriteEnable,
  output logic [DATA_WIDTH-1:0]         ringData,
  input  logic                          ringDataReadAck,
  output logic [LENGTH_BITS:0]          occupancy,
  output logic                          full,
  output logic                          empty
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam logic [IDX_W-1:0]     LAST_INIT = IDX_W'(NUM_REQ - 1);
  localparam logic [LENGTH_BITS:0] CAP_OCC   = (LENGTH_BITS + 1)'(CAPACITY);

  logic [IDX_W-1:0]      last_grant;
  logic [NUM_REQ-1:0]    pick_grant;
  logic [IDX_W-1:0]      pick_winner;
  logic [DATA_WIDTH-1:0] win_data;
  logic                  fire;
  occ_op_e               occ_op;

  rr_priority_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_picker (
    .req        (reqValid),
    .last_grant (last_grant),
    .grant      (pick_grant),
    .winner     (pick_winner)
  );

  // Status comes from the registered count only; a read ack frees a slot for
  // granting starting the following cycle.
  assign full  = (occupancy == CAP_OCC);
  assign empty = (occupancy == '0);

  // No grants while full or while reset is held.
  assign reqGrant = (reset && !full) ? pick_grant : '0;
  assign fire     = |reqGrant;

  // Select the granted producer's data slice.
  always_comb begin
    win_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_grant[i]) win_data = reqData[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Register the write strobe/data toward RingBuffer and advance the pointer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ringWriteEnable <= 1'b0;
      ringData        <= '0;
      last_grant      <= LAST_INIT;
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      ringWriteEnable <= fire;
      if (fire) begin
        ringData   <= win_data;
        last_grant <= pick_winner;
      end
    end
  end

  // Decide how occupancy moves this edge; simultaneous grant and ack cancel.
  always_comb begin
    occ_op = OCC_HOLD;
    unique case ({fire, ringDataReadAck})
      2'b10:   occ_op = OCC_INC;
      2'b01:   occ_op = (occupancy != '0) ? OCC_DEC : OCC_HOLD;
      default: occ_op = OCC_HOLD;
    endcase
  end

  // Occupancy counter; a stray ack at zero saturates instead of wrapping.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      occupancy <= '0;
    end else begin
      unique case (occ_op)
        OCC_INC: occupancy <= occupancy + 1'b1;
        OCC_DEC: occupancy <= occupancy - 1'b1;
        default: occupancy <= occupancy;
      endcase
    end
  end

  // An ack with nothing outstanding means the consumer side is misbehaving.
  ack_without_entry: assert property (
    @(posedge clk) disable iff (!reset) !(ringDataReadAck && empty)
  );

endmodule

// File: doc/ring_write_arbiter.md
Name: ring_write_arbiter

Overview:
- Shares the single write port of one RingBuffer instance among NUM_REQ independent producers.
- Round-robin arbitration, one accepted write per clock.
- Tracks buffer occupancy internally, counting accepted writes and returned read acks, and never issues a write that would overflow the buffer.
- Sits directly in front of RingBuffer's writeEnable/data inputs; RingBuffer's dataReadAck is fed back to it.

Parameters:
- NUM_REQ, 4, number of producers (2..8).
- DATA_WIDTH, 8, data width; matches RingBuffer's data width.
- LENGTH_BITS, 3, RingBuffer length parameter (log2 of slot count).
- CAPACITY, 2**LENGTH_BITS-1, usable entries; one slot is reserved by RingBuffer.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset (asserted when 0)
- reqValid  in  NUM_REQ  per-producer write request
- reqData  in  NUM_REQ*DATA_WIDTH  producer i data in bits [i*DATA_WIDTH +: DATA_WIDTH]
- reqGrant  out  NUM_REQ  one-hot, combinational; transfer occurs when reqValid[i] & reqGrant[i] at the rising edge
- ringWriteEnable  out  1  registered write strobe to RingBuffer writeEnable
- ringData  out  DATA_WIDTH  registered write data to RingBuffer data
- ringDataReadAck  in  1  RingBuffer dataReadAck; one entry consumed
- occupancy  out  LENGTH_BITS+1  entries accepted and not yet read
- full  out  1  occupancy == CAPACITY
- empty  out  1  occupancy == 0

Behaviour:
- Reset while reset==0, asynchronous:
  - ringWriteEnable=0, ringData=0, occupancy=0, full=0, empty=1.
  - Round-robin pointer lastGrant=NUM_REQ-1, so requester 0 has first priority.
  - reqGrant=0 while reset is asserted.
- Reset mid-operation: everything above is cleared immediately. RingBuffer must share the same reset net, so any in-flight write is discarded by both blocks.
- Arbitration, combinational, each cycle:
  - If full==1, reqGrant=0.
  - Otherwise search i = lastGrant+1, lastGrant+2, ... modulo NUM_REQ.
  - The first i with reqValid[i]==1 gets reqGrant[i]=1; no other bit is set.
- Producer handshake:
  - A producer holds reqValid and its data stable until it sees its grant at a clock edge.
  - It may change data or drop reqValid after that edge.
  - reqGrant never depends on a producer's own next-cycle behaviour.
- On the edge where a grant occurs:
  - ringWriteEnable<=1; ringData<=winner's data; lastGrant<=winner.
- On an edge with no grant: ringWriteEnable<=0; ringData holds its value.
- Latency: request accepted in cycle N; RingBuffer sees the write strobe during cycle N+1.
- Occupancy update per edge:
  - +1 on grant without ack.
  - -1 on ringDataReadAck without grant.
  - Unchanged when both or neither occur.
- An ack arriving while occupancy==0 is a protocol error. Occupancy saturates at 0. A simulation-only assertion fires.
- full and empty are derived from registered occupancy. There is no same-cycle bypass: an ack at full enables a grant from the next cycle only.
- A requester is never starved. With all requesters active, each one is granted at least once every NUM_REQ grants.

Decomposition:
- Shared package ring_pkg holds:
  - default constants RING_DATA_WIDTH=8 and RING_LENGTH_BITS=3.
  - function ring_capacity(lengthBits) = 2**lengthBits-1, reused by RingBuffer users.
- Natural sub-module: rr_priority_picker. It is purely combinational and takes request vector + lastGrant, returning a one-hot grant plus winner index. It is reused by later schedulers.
- Occupancy counter and output registers stay in ring_write_arbiter.

Test Plan (NUM_REQ=4, DATA_WIDTH=8, LENGTH_BITS=3, CAPACITY=7):
- Reset: hold reset=0 for 2 cycles -> ringWriteEnable=0, ringData=0, occupancy=0, empty=1, full=0, reqGrant=0.
- Single requester: reqValid=4'b0100, data[2]=0x11 -> reqGrant=4'b0100 the same cycle; next cycle ringWriteEnable=1, ringData=0x11, occupancy=1, empty=0.
- Fairness: all four valid continuously with distinct data 0xA0..0xA3 -> grants 0,1,2,3 on consecutive cycles; ringData sequence 0xA0,0xA1,0xA2,0xA3; full after 7 grants.
- Full/backpressure: requester 0 offers 0x01..0x09 with no reads:
  - 7 grants, occupancy=7, full=1, reqGrant=0 with 0x08 held.
  - Pulse ringDataReadAck for 1 cycle -> occupancy=6 and full=0 next cycle; 0x08 granted that cycle.
- Simultaneous grant and ack at occupancy=3 -> occupancy stays 3; ringWriteEnable=1.
- Async reset mid-burst: drop reset between edges during the fairness test -> ringWriteEnable=0 immediately and occupancy=0. After release, the first grant goes to requester 0.
